problemalcd_button_ctrl: RTL

Avalon-MM slave that takes over the LCD menu push-buttons from the bare per-button input PIOs. It synchronises and debounces N raw button lines and turns each clean press into a latched event. Events are held in an edge-capture register with a per-button interrupt mask and a level IRQ. It sits on the Nios II data bus next to the LCD controller and lets the menu software act on single, glitch-free press events instead of polling raw levels.

---
 rtl/problemalcd_button_ctrl_pkg.sv | 20 ++
 rtl/problemalcd_button_ctrl_debounce.sv | 118 +++++++++++
 rtl/problemalcd_button_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/problemalcd_button_ctrl_pkg.sv
// Shared types and register map for the LCD menu push-button controller.
package problemalcd_button_ctrl_pkg;

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    CHK_PRESS = 2'd1,
    PRESSED   = 2'd2,
    CHK_REL   = 2'd3
  } deb_state_e;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // A button reads as pressed until its release has been confirmed.
  function automatic logic deb_is_pressed(input deb_state_e s);
    return (s == PRESSED) || (s == CHK_REL);
  endfunction

endpackage

// File: rtl/problemalcd_button_ctrl_debounce.sv
// One button line: 2-flop synchroniser, polarity fix, debounce FSM and
// optional auto-repeat (PROBLEMALCD_BUTTON_CTRL_AUTOREPEAT_EN).
module problemalcd_button_ctrl_debounce
  import problemalcd_button_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          ACTIVE_LOW      = 1'b1
`ifdef PROBLEMALCD_BUTTON_CTRL_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
`endif
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_level_c,
  output logic o_press_c
);

  localparam int unsigned CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic RAW_IDLE = ACTIVE_LOW;

  logic          r_sync1;
  logic          r_sync2;
  logic          w_synced;
  deb_state_e    r_state;
  logic [CW-1:0] r_cnt;
  logic          w_deb_press;

  // Bring the asynchronous line into the clock domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= RAW_IDLE;
      r_sync2 <= RAW_IDLE;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_synced = ACTIVE_LOW ? ~r_sync2 : r_sync2;

  // Debounce FSM; the counter only advances below its last value, so it never wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RELEASED;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        RELEASED: begin
          if (w_synced) begin
            r_cnt   <= '0;
            r_state <= CHK_PRESS;
          end
        end
        CHK_PRESS: begin
          if (!w_synced)              r_state <= RELEASED;
          else if (r_cnt == CNT_LAST) r_state <= PRESSED;
          else                        r_cnt   <= r_cnt + CW'(1);
        end
        PRESSED: begin
          if (!w_synced) begin
            r_cnt   <= '0;
            r_state <= CHK_REL;
          end
        end
        CHK_REL: begin
          if (w_synced)               r_state <= PRESSED;
          else if (r_cnt == CNT_LAST) r_state <= RELEASED;
          else                        r_cnt   <= r_cnt + CW'(1);
        end
        default: r_state <= RELEASED;
      endcase
    end
  end

  // The press pulse is high in the cycle whose edge enters PRESSED.
  assign w_deb_press = (r_state == CHK_PRESS) && w_synced && (r_cnt == CNT_LAST);
  assign o_level_c   = deb_is_pressed(r_state);

`ifdef PROBLEMALCD_BUTTON_CTRL_AUTOREPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  logic [RW-1:0] r_rep_cnt;
  logic          r_rep_first;
  logic [RW-1:0] w_rep_target;
  logic          w_rep_hit;

  assign w_rep_target = r_rep_first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
  assign w_rep_hit    = (r_state == PRESSED) && w_synced && (r_rep_cnt == w_rep_target);

  // Repeat timer: first event after the delay, then one per period while held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
    end else if (r_state != PRESSED) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
    end else if (w_synced) begin
      if (w_rep_hit) begin
        r_rep_cnt   <= '0;
        r_rep_first <= 1'b0;
      end else begin
        r_rep_cnt   <= r_rep_cnt + RW'(1);
      end
    end
  end

  assign o_press_c = w_deb_press | w_rep_hit;
`else
  assign o_press_c = w_deb_press;
`endif

endmodule

// File: rtl/problemalcd_button_ctrl.sv
// Avalon-MM push-button controller: debounced levels, masked press-event
// capture and a level IRQ. Auto-repeat: PROBLEMALCD_BUTTON_CTRL_AUTOREPEAT_EN.
module problemalcd_button_ctrl
  import problemalcd_button_ctrl_pkg::*;
#(
  parameter int unsigned N_BUTTONS       = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          ACTIVE_LOW      = 1'b1
`ifdef PROBLEMALCD_BUTTON_CTRL_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
`endif
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [31:0]          writedata,
  input  logic [N_BUTTONS-1:0] in_port,
  output logic [31:0]          readdata,
  output logic                 irq
);

  logic [N_BUTTONS-1:0] w_level;
  logic [N_BUTTONS-1:0] w_press;
  logic [N_BUTTONS-1:0] r_mask;
  logic [N_BUTTONS-1:0] r_edge;
  logic [N_BUTTONS-1:0] w_clr;
  logic [N_BUTTONS-1:0] w_wdata;
  logic                 w_wr;
  logic [31:0]          w_rd_mux;
  logic                 w_unused_wdata;

  // One independent debouncer per button line.
  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_btn
    problemalcd_button_ctrl_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
`ifdef PROBLEMALCD_BUTTON_CTRL_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_deb (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_raw     (in_port[g]),
      .o_level_c (w_level[g]),
      .o_press_c (w_press[g])
    );
  end

  assign w_wr           = chipselect & ~write_n;
  assign w_wdata        = writedata[N_BUTTONS-1:0];
  assign w_unused_wdata = ^writedata;
  assign w_clr          = (w_wr && (address == ADDR_EDGE)) ? w_wdata : '0;

  // Mask register and edge capture; a press in the clearing cycle wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= '0;
      r_edge <= '0;
    end else begin
      if (w_wr && (address == ADDR_MASK)) r_mask <= w_wdata;
      r_edge <= (r_edge & ~w_clr) | w_press;
    end
  end

  // Read mux; unused addresses and upper bits read 0.
  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA: w_rd_mux = 32'(w_level);
      ADDR_MASK: w_rd_mux = 32'(r_mask);
      ADDR_EDGE: w_rd_mux = 32'(r_edge);
      default:   w_rd_mux = '0;
    endcase
  end

  // Read data refreshed every cycle, no chipselect needed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= w_rd_mux;
  end

  assign irq = |(r_edge & r_mask);

endmodule
